// File: rtl/rv32i_lsu_stage.sv
// rv32i_lsu_stage: RV32I load/store stage with bus handshake, timeout abort and forwarding taps.
// Ports: clk/reset (sync, active-high); in_valid/in_ready handshake with execute-stage operands;
// bus_* request/ack memory port (IO window at IO_BASE); registered writeback outputs plus df_* forwarding.
// Optional macro RV32I_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into immediate errors.
module rv32i_lsu_stage #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int          TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_en_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  width_in,
  input  logic        unsigned_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic        err_out,
  output logic        df_enable,
  output logic [4:0]  df_reg,
  output logic [31:0] df_data
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        st;
    logic [1:0]  w;
    logic        u;
  } req_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] iw;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } out_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  req_t req_q, req_d;
  out_t o_q, o_d;
  logic mem, mis, bad;
  logic [31:0] sh, ld;
  assign mem = is_load | is_store;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  assign mis = (width_in == 2'b01 & alu_in[0]) | (width_in == 2'b10 & alu_in[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign bad = width_in == 2'b11 | mis;
  // Lane select of the returned word, then sign/zero extension.
  assign sh = req_q.w == 2'b00 ? bus_rdata >> {req_q.alu[1:0], 3'b000} :
              req_q.w == 2'b01 ? bus_rdata >> {req_q.alu[1], 4'b0000} : bus_rdata;
  assign ld = req_q.w == 2'b00 ? {{24{~req_q.u & sh[7]}}, sh[7:0]} :
              req_q.w == 2'b01 ? {{16{~req_q.u & sh[15]}}, sh[15:0]} : sh;
  assign in_ready  = state_q == IDLE;
  assign bus_req   = state_q == BUS;
  assign bus_we    = bus_req & req_q.st;
  assign bus_io    = bus_req & (req_q.alu >= IO_BASE);
  assign bus_addr  = bus_req ? req_q.alu[31:2] : 30'd0;
  assign bus_be    = !bus_req ? 4'b0000 :
                     req_q.w == 2'b00 ? 4'b0001 << req_q.alu[1:0] :
                     req_q.w == 2'b01 ? 4'b0011 << {req_q.alu[1], 1'b0} : 4'b1111;
  assign bus_wdata = !bus_req ? 32'd0 :
                     req_q.w == 2'b00 ? {4{req_q.rs2[7:0]}} :
                     req_q.w == 2'b01 ? {2{req_q.rs2[15:0]}} : req_q.rs2;
  assign out_valid   = o_q.valid;
  assign pc_out      = o_q.pc;
  assign iw_out      = o_q.iw;
  assign wb_data_out = o_q.data;
  assign wb_reg_out  = o_q.rd;
  assign wb_en_out   = o_q.wen;
  assign err_out     = o_q.err;
  assign df_enable   = o_q.valid & o_q.wen;
  assign df_reg      = o_q.rd;
  assign df_data     = o_q.data;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    o_d = o_q;
    o_d.valid = 1'b0;
    o_d.err = 1'b0;
    if (state_q == IDLE && in_valid) begin
      req_d = {pc_in, iw_in, alu_in, rs2_data_in, wb_reg_in, wb_en_in, is_store, width_in, unsigned_in};
      if (mem && !bad) begin
        state_d = BUS;
        cnt_d = 8'd0;
      end else begin
        // Non-memory ops and rejected memory ops both complete without touching the bus.
        o_d = {1'b1, pc_in, iw_in, alu_in, wb_reg_in, wb_en_in & ~mem, mem};
      end
    end else if (state_q == BUS) begin
      if (bus_ack) begin
        state_d = DONE;
        o_d = {1'b1, req_q.pc, req_q.iw, req_q.st ? req_q.alu : ld, req_q.rd, req_q.wen & ~req_q.st, 1'b0};
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = DONE;
        o_d = {1'b1, req_q.pc, req_q.iw, req_q.alu, req_q.rd, 1'b0, 1'b1};
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      req_q <= '0;
      o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      o_q <= o_d;
    end
  end
endmodule

// File: tb/tb_rv32i_lsu_stage.sv
// tb_rv32i_lsu_stage: directed and randomized checks of rv32i_lsu_stage against a behavioural model.
module tb_rv32i_lsu_stage;
  localparam int TMO = 16;
  logic clk = 0, reset = 1, in_valid = 0, in_ready;
  logic [31:0] pc_in = 0, iw_in = 0, alu_in = 0, rs2_data_in = 0;
  logic [4:0] wb_reg_in = 0;
  logic wb_en_in = 0, is_load = 0, is_store = 0, unsigned_in = 0;
  logic [1:0] width_in = 0;
  logic bus_req, bus_we, bus_io, bus_ack = 0;
  logic [29:0] bus_addr;
  logic [3:0] bus_be;
  logic [31:0] bus_wdata, bus_rdata = 0;
  logic out_valid, wb_en_out, err_out, df_enable;
  logic [31:0] pc_out, iw_out, wb_data_out, df_data;
  logic [4:0] wb_reg_out, df_reg;
  int checks = 0, errors = 0;
  rv32i_lsu_stage #(.IO_BASE(32'h8000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
    .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .is_load(is_load), .is_store(is_store),
    .width_in(width_in), .unsigned_in(unsigned_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out), .err_out(err_out),
    .df_enable(df_enable), .df_reg(df_reg), .df_data(df_data));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] w, input logic u);
    longint v;
    if (w == 0) begin
      v = (rd >> (8 * (a % 4))) % 256;
      if (!u && v >= 128) v = v - 256;
    end else if (w == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end else v = rd;
    return 32'(v);
  endfunction
  function automatic logic [3:0] be_val(input logic [31:0] a, input logic [1:0] w);
    return w == 0 ? 4'(1 << (a % 4)) : w == 1 ? 4'(3 << (2 * ((a / 2) % 2))) : 4'd15;
  endfunction
  function automatic logic [31:0] wd_val(input logic [31:0] r, input logic [1:0] w);
    return w == 0 ? (r % 256) * 32'h0101_0101 : w == 1 ? (r % 65536) * 32'h0001_0001 : r;
  endfunction
  function automatic logic rejected(input logic [31:0] a, input logic [1:0] w);
    logic m = 0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    m = (w == 1 && a % 2 != 0) || (w == 2 && a % 4 != 0);
`endif
    return w == 3 || m;
  endfunction
  task automatic check_out(input logic [31:0] pc, iw, data, input logic [4:0] rd, input logic wen, err, chk_data);
    chk("out_valid", out_valid, 1);
    chk("err_out", err_out, err);
    chk("wb_en_out", wb_en_out, wen);
    chk("pc_out", pc_out, pc);
    chk("iw_out", iw_out, iw);
    chk("wb_reg_out", wb_reg_out, rd);
    chk("df_enable", df_enable, wen);
    chk("df_reg", df_reg, rd);
    if (chk_data) begin
      chk("wb_data_out", wb_data_out, data);
      chk("df_data", df_data, data);
    end
  endtask
  // Issues one instruction and follows it to completion; ack_at counts BUS cycles from 1, beyond TMO means never.
  task automatic run_op(input logic [31:0] a, r2, input logic [4:0] rd, input logic wen, ldi, sti,
                        input logic [1:0] w, input logic u, input int ack_at, input logic [31:0] rdata);
    logic [31:0] pc = $urandom, iw = $urandom;
    logic mem = ldi | sti;
    int k = 1;
    logic acked = 0;
    chk("in_ready_idle", in_ready, 1);
    {pc_in, iw_in, alu_in, rs2_data_in, wb_reg_in, wb_en_in} = {pc, iw, a, r2, rd, wen};
    {is_load, is_store, width_in, unsigned_in, bus_rdata} = {ldi, sti, w, u, rdata};
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    if (!mem || rejected(a, w)) begin
      chk("bus_req_none", bus_req, 0);
      check_out(pc, iw, a, rd, wen && !mem, mem, !mem);
      chk("in_ready_fast", in_ready, 1);
    end else begin
      forever begin
        chk("bus_req", bus_req, 1);
        chk("in_ready_bus", in_ready, 0);
        chk("out_valid_bus", out_valid, 0);
        chk("bus_we", bus_we, sti);
        chk("bus_io", bus_io, a >= 32'h8000_0000);
        chk("bus_addr", bus_addr, a / 4);
        chk("bus_be", bus_be, be_val(a, w));
        chk("bus_wdata", bus_wdata, wd_val(r2, w));
        acked = k == ack_at;
        bus_ack = acked;
        @(negedge clk);
        bus_ack = 0;
        if (acked || k == TMO) break;
        k++;
      end
      chk("bus_req_done", bus_req, 0);
      chk("in_ready_done", in_ready, 0);
      check_out(pc, iw, load_val(a, rdata, w, u), rd, wen && ldi && acked, !acked, ldi && acked);
    end
    @(negedge clk);
    chk("out_valid_pulse", out_valid, 0);
    chk("err_pulse", err_out, 0);
    chk("in_ready_after", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_outs", {pc_out ^ iw_out ^ wb_data_out, 27'd0, wb_reg_out} | {31'd0, wb_en_out | err_out | df_enable}, 0);
    reset = 0;
    run_op(32'h1234, 0, 5, 1, 0, 0, 2'b10, 0, 0, 0);
    chk("s033_data", wb_data_out, 32'h1234);
    run_op(32'h103, 0, 7, 1, 1, 0, 2'b00, 0, 3, 32'h80AB_CDEF);
    chk("s034_data", wb_data_out, 32'hFFFF_FF80);
    run_op(32'h8000_0002, 32'h0000_ABCD, 9, 1, 0, 1, 2'b01, 0, 2, 0);
    run_op(32'h200, 0, 3, 1, 1, 0, 2'b10, 0, 99, 32'h1111_2222);
    run_op(32'h204, 0, 3, 1, 1, 0, 2'b10, 0, TMO, 32'h3333_4444);
    chk("s036_ack16", wb_data_out, 32'h3333_4444);
    run_op(32'h102, 0, 4, 1, 1, 0, 2'b10, 0, 1, 32'hCAFE_F00D);
    run_op(32'h300, 0, 4, 1, 1, 0, 2'b11, 0, 1, 0);
    run_op(32'h301, 0, 6, 1, 1, 0, 2'b01, 1, 1, 32'h89AB_CDEF);
    // Reset while a request is on the bus.
    {alu_in, is_load, is_store, width_in, in_valid} = {32'h400, 1'b1, 1'b0, 2'b10, 1'b1};
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_bus_req", bus_req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_bus_req_drop", bus_req, 0);
    chk("rst_bus_in_ready", in_ready, 1);
    chk("rst_bus_out_valid", out_valid, 0);
    @(negedge clk);
    chk("rst_bus_no_valid", out_valid, 0);
    chk("rst_bus_no_req", bus_req, 0);
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      run_op($urandom, $urandom, 5'($urandom), 1'($urandom), kind == 1, kind == 2,
             2'($urandom), 1'($urandom), ($urandom % 8 == 0) ? 99 : $urandom_range(1, 5), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_lsu_stage.md
RV32I_LSU_STAGE -- requirements
Module: rv32i_lsu_stage

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h8000_0000; addresses >= IO_BASE target IO, below target RAM.
REQ-002 SHALL have parameter TIMEOUT, default 16; maximum bus wait cycles before abort, range 1..255.
REQ-003 SHALL have port clk, input, 1, system clock, rising-edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1, stage can accept; low means stall upstream.
REQ-007 SHALL have ports pc_in, iw_in, alu_in, rs2_data_in, each input, 32, from execute.
REQ-008 SHALL have ports wb_reg_in (input, 5) and wb_en_in (input, 1), destination register and its writeback enable.
REQ-009 SHALL have ports is_load and is_store, each input, 1, never both high.
REQ-010 SHALL have ports width_in (input, 2: 00 byte, 01 half, 10 word, 11 reserved) and unsigned_in (input, 1, zero-extend loads).
REQ-011 SHALL have bus outputs bus_req (1), bus_we (1), bus_io (1, IO target), bus_addr (30, [31:2]), bus_be (4), bus_wdata (32).
REQ-012 SHALL have bus inputs bus_ack (1) and bus_rdata (32).
REQ-013 SHALL have outputs out_valid (1), pc_out (32), iw_out (32), wb_data_out (32), wb_reg_out (5), wb_en_out (1), err_out (1).
REQ-014 SHALL have forwarding outputs df_enable (1), df_reg (5), df_data (32), each combinational from the output registers.

Function
REQ-015 SHALL implement FSM IDLE, BUS, DONE; in_ready = (state == IDLE).
REQ-016 In IDLE, with in_valid and neither is_load nor is_store: SHALL register inputs, wb_data_out = alu_in, out_valid high next cycle; 1-cycle latency.
REQ-017 In IDLE, with in_valid and (is_load or is_store): SHALL latch request, enter BUS, assert bus_req from the next cycle.
REQ-018 In BUS: bus_req, bus_we (= is_store), bus_io, bus_addr = alu_in[31:2], bus_be, and bus_wdata SHALL be held stable until bus_ack or timeout.
REQ-019 bus_be SHALL be byte 4'b0001<<a[1:0], half 4'b0011<<{a[1],1'b0}, word 4'b1111.
REQ-020 bus_wdata SHALL be byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
REQ-021 Load data SHALL be extracted from bus_rdata using alu_in[1:0] and width_in, then sign-extended, or zero-extended when unsigned_in is set.
REQ-022 On bus_ack in BUS: SHALL capture result, go to DONE, drop bus_req the next cycle; DONE presents out_valid for one cycle and returns to IDLE.
REQ-023 Store completion SHALL force wb_en_out = 0.
REQ-024 A wait counter SHALL count BUS cycles; after TIMEOUT cycles without bus_ack: abort, err_out = 1, wb_en_out = 0, go to DONE.
REQ-025 bus_ack in the same cycle as counter expiry SHALL win (normal completion, no error).
REQ-026 width_in = 11 on a memory op SHALL issue no bus request and complete after 1 cycle with err_out = 1 and wb_en_out = 0.
REQ-027 out_valid and err_out SHALL be single-cycle pulses; other outputs hold until the next completion.
REQ-028 df_enable SHALL equal out_valid & wb_en_out, df_reg = wb_reg_out, df_data = wb_data_out.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, all outputs 0 except in_ready = 1, on the next rising edge.
REQ-030 Reset during BUS SHALL drop bus_req on the next edge, discard the request, and produce no out_valid.

Configuration
REQ-031 Macro RV32I_LSU_MISALIGN_TRAP_EN defined: half at odd address or word at a[1:0] != 0 SHALL issue no bus request and complete after 1 cycle with err_out = 1, wb_en_out = 0.
REQ-032 Macro undefined: misaligned word SHALL be aligned down (a[1:0] ignored), half SHALL use a[1] only, no error.

Verification
REQ-033 Scenario: ALU op, alu_in=0x1234, wb_en=1, reg 5 -> next cycle out_valid=1, wb_data_out=0x1234, df_enable=1, df_reg=5.
REQ-034 Scenario: signed byte load at 0x103, ack after 3 cycles, rdata=0x80xxxxxx -> bus_be=1000, wb_data_out=0xFFFFFF80, in_ready low 4 cycles.
REQ-035 Scenario: half store rs2=0xABCD at 0x8000_0002 -> bus_io=1, bus_be=1100, bus_wdata=0xABCDABCD, wb_en_out=0.
REQ-036 Scenario: load, no ack, TIMEOUT=16 -> abort after 16 BUS cycles, err_out pulse, wb_en_out=0; ack on cycle 16 instead -> no error.
REQ-037 Scenario: word load at 0x102 -> with macro: err_out=1, no bus_req; without: bus_addr=0x40 ([31:2]), normal completion.
REQ-038 Scenario: reset asserted during BUS -> bus_req 0 next cycle, state IDLE, no out_valid.
